led_pattern_engine: RTL
=======================

Name: led_pattern_engine

Overview:
- Parametrised successor to the board-level LED sequencer: drives N_LEDS mono LEDs plus N_LEDS RGB LEDs from one pattern register.
- The pattern register advances on a prescaler tick with four selectable rates, in one of four modes: shift, flash, bounce, hold.
- Sits between the synchronised switch/button inputs and the LED pins inside top.

Parameters:
- N_LEDS, 4, number of LEDs per bank; must be at least 1.
- CNT_WIDTH, 32, prescaler counter width.
- LIMIT_0, 3, terminal count for rate select 0; tick period is LIMIT_0+1 enabled cycles.
- LIMIT_1, 7, terminal count for rate select 1.
- LIMIT_2, 15, terminal count for rate select 2.
- LIMIT_3, 31, terminal count for rate select 3.

Ports:
- clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  1 = prescaler counts; 0 = counter and pattern freeze.
- i_rate_sel  in  2  selects LIMIT_0..LIMIT_3.
- i_dir  in  1  1 = left (toward MSB); 0 = right (toward LSB).
- i_mode  in  2  00 shift, 01 flash, 10 bounce, 11 hold.
- i_color  in  3  colour mask: bit0 R, bit1 G, bit2 B.
- o_led  out  N_LEDS  mono LED bank, equal to the pattern register.
- o_led_r  out  N_LEDS  pattern AND {N_LEDS{i_color[0]}}.
- o_led_g  out  N_LEDS  pattern AND {N_LEDS{i_color[1]}}.
- o_led_b  out  N_LEDS  pattern AND {N_LEDS{i_color[2]}}.
- o_tick  out  1  one-cycle pulse when the prescaler wraps.

Behaviour:
Reset (asynchronous, i_reset=1):
- counter=0, pattern=1 (one-hot, bit0), mode_q=00, bounce_dir=left.
- o_tick=0; o_led=1; RGB outputs equal the mask applied to 1.
- Reset asserted mid-sequence aborts it immediately, with no clock edge required.

Prescaler:
- sel_limit = LIMIT[i_rate_sel].
- tick (combinational) = i_enable AND (counter >= sel_limit). The >= comparison guarantees a tick on the next enabled cycle after a switch to a lower limit.
- On tick: counter <= 0. Else, if i_enable: counter <= counter+1. Else: counter holds.
- o_tick is tick registered, so it is high for exactly one cycle, one cycle after the wrap edge.
- From reset release with i_enable=1, the first pattern change is visible on o_led after sel_limit+1 rising edges.

Mode change (priority over tick):
- When i_mode != mode_q: mode_q <= i_mode and counter <= 0.
- Pattern reload on mode change:
  - shift or bounce: pattern <= 1, bounce_dir <= left.
  - flash: pattern <= all ones.
  - hold: pattern unchanged.
- Any tick in that same cycle is discarded.

On tick, by mode_q:
- shift, i_dir=1: rotate left; MSB wraps to bit0.
- shift, i_dir=0: rotate right; bit0 wraps to MSB.
- Shift rotates whatever pattern is loaded; the pattern is not forced back to one-hot.
- flash: pattern <= ~pattern, toggling between all ones and all zeros.
- bounce: the one-hot walks in bounce_dir and i_dir is ignored.
  - When bit N_LEDS-1 is set while moving left, move to bit N_LEDS-2 and set bounce_dir=right.
  - Symmetric behaviour at bit0 while moving right.
  - Each end LED lights for exactly one tick period per pass.
- bounce, N_LEDS=1: pattern stays 1.
- hold: no change; the counter keeps running and o_tick still pulses.

Other rules:
- i_enable=0: the pattern freezes, but a mode change still reloads it.
- i_color is combinational masking only and has no effect on state.
- All arithmetic is unsigned at CNT_WIDTH; LIMIT_x must be below 2^CNT_WIDTH.

Test Plan:
- Reset release, mode 00, i_dir=1, rate 0, enable=1 -> o_led sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles. o_tick pulses every 4 cycles.
- Shift, i_dir=0, rate 1 -> sequence 0001, 1000, 0100, 0010, each held 8 cycles. Drop i_enable for 20 cycles -> o_led and counter frozen; on re-enable the remaining count of the current period completes.
- Switch to flash, i_color=3'b001 -> the cycle after the change, o_led=1111, o_led_r=1111, o_led_g=0000, o_led_b=0000. Then 0000 and 1111 alternate every 4 cycles at rate 0.
- Bounce at rate 0 -> sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, each held 4 cycles, with i_dir toggled randomly. Mode change coinciding with a tick -> pattern=0001 and the counter restarts from 0.
- Rate 3 with counter at 20, switch to rate 0 -> tick on the next cycle, then a 4-cycle period.
- Assert i_reset for 3 ns between edges during bounce -> outputs return to reset values immediately. After release, the first change appears after LIMIT+1 edges.

Source files
------------

// File: rtl/led_pattern_engine.sv
// LED pattern engine: a prescaled pattern register (shift / flash / bounce / hold)
// driving a mono LED bank and a colour-masked RGB bank.
module led_pattern_engine #(
   parameter int N_LEDS    = 4,
   parameter int CNT_WIDTH = 32,
   parameter int LIMIT_0   = 3,
   parameter int LIMIT_1   = 7,
   parameter int LIMIT_2   = 15,
   parameter int LIMIT_3   = 31
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [1:0]        i_rate_sel,
   input  logic              i_dir,
   input  logic [1:0]        i_mode,
   input  logic [2:0]        i_color,
   output logic [N_LEDS-1:0] o_led,
   output logic [N_LEDS-1:0] o_led_r,
   output logic [N_LEDS-1:0] o_led_g,
   output logic [N_LEDS-1:0] o_led_b,
   output logic              o_tick
);

   localparam logic [1:0] MODE_SHIFT  = 2'b00;
   localparam logic [1:0] MODE_FLASH  = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   localparam logic [N_LEDS-1:0] PAT_ONE  = N_LEDS'(1);
   localparam logic [N_LEDS-1:0] PAT_ALL  = {N_LEDS{1'b1}};

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [N_LEDS-1:0]    pat_q, pat_d;
   logic [1:0]           mode_q, mode_d;
   logic                 bdir_q, bdir_d;
   logic                 tick_q, tick_d;

   logic [CNT_WIDTH-1:0] sel_limit;
   logic                 tick;

   always_comb begin
      case (i_rate_sel)
         2'd0:    sel_limit = CNT_WIDTH'(LIMIT_0);
         2'd1:    sel_limit = CNT_WIDTH'(LIMIT_1);
         2'd2:    sel_limit = CNT_WIDTH'(LIMIT_2);
         default: sel_limit = CNT_WIDTH'(LIMIT_3);
      endcase
   end

   // >= rather than == so a switch to a shorter period ticks right away.
   assign tick = i_enable && (cnt_q >= sel_limit);

   always_comb begin
      cnt_d  = cnt_q;
      pat_d  = pat_q;
      mode_d = mode_q;
      bdir_d = bdir_q;
      tick_d = 1'b0;
      if (i_mode != mode_q) begin
         // A mode change wins over a coincident tick, which is dropped.
         mode_d = i_mode;
         cnt_d  = '0;
         case (i_mode)
            MODE_SHIFT, MODE_BOUNCE: begin
               pat_d  = PAT_ONE;
               bdir_d = DIR_LEFT;
            end
            MODE_FLASH: pat_d = PAT_ALL;
            default:    pat_d = pat_q;
         endcase
      end else if (tick) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         case (mode_q)
            MODE_SHIFT: begin
               if (i_dir)
                  pat_d = (pat_q << 1) | (pat_q >> (N_LEDS - 1));
               else
                  pat_d = (pat_q >> 1) | (pat_q << (N_LEDS - 1));
            end
            MODE_FLASH: pat_d = ~pat_q;
            MODE_BOUNCE: begin
               if (N_LEDS == 1) begin
                  pat_d = pat_q;
               end else if (bdir_q == DIR_LEFT) begin
                  if (pat_q[N_LEDS-1]) begin
                     pat_d  = pat_q >> 1;
                     bdir_d = DIR_RIGHT;
                  end else begin
                     pat_d = pat_q << 1;
                  end
               end else begin
                  if (pat_q[0]) begin
                     pat_d  = pat_q << 1;
                     bdir_d = DIR_LEFT;
                  end else begin
                     pat_d = pat_q >> 1;
                  end
               end
            end
            default: pat_d = pat_q;
         endcase
      end else if (i_enable) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         cnt_q  <= '0;
         pat_q  <= PAT_ONE;
         mode_q <= MODE_SHIFT;
         bdir_q <= DIR_LEFT;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pat_q  <= pat_d;
         mode_q <= mode_d;
         bdir_q <= bdir_d;
         tick_q <= tick_d;
      end
   end

   assign o_led   = pat_q;
   assign o_led_r = pat_q & {N_LEDS{i_color[0]}};
   assign o_led_g = pat_q & {N_LEDS{i_color[1]}};
   assign o_led_b = pat_q & {N_LEDS{i_color[2]}};
   assign o_tick  = tick_q;

endmodule
